alu_exec_unit: RTL and testbench

- Parametrised execute unit: decodes the operation class from `alu_funct`/`funct3`/`funct7` and computes the result.
- Covers RV32I ALU ops, branch resolution and RV32M multiply/divide.
- Single-cycle ops complete with 1-cycle latency; MUL/DIV iterate over multiple cycles.
- Sits between the decode and writeback stages, with valid/ready handshakes on both sides.

---
 rtl/alu_exec_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I ALU/branch execute unit with iterative RV32M ops
// Optional MUL/DIV group and iteration datapath enabled by macro ALU_EXEC_MULDIV_EN.
module alu_exec_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_funct,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_taken,
  output logic            illegal_op,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [2:0] CTL_ALU_ADD = 3'd0;
  localparam logic [2:0] CTL_ALU_REG = 3'd1;
  localparam logic [2:0] CTL_ALU_IMM = 3'd2;
  localparam logic [2:0] CTL_ALU_BR  = 3'd3;
  localparam logic [2:0] CTL_ALU_LUI = 3'd4;
  localparam logic [XLEN-1:0] ZERO = '0;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            accept, idle, done_fire, iter_start;
  logic            start_mul, start_div;
  logic [XLEN-1:0] sc_result, base_res, sra_res, md_result;
  logic            sc_br, sc_illegal;
  logic [SH_W-1:0] shamt;
  logic            eq, lt_s, lt_u;

  assign accept     = in_valid & in_ready;
  assign in_ready   = rst_n & idle & (~out_valid | out_ready);
  assign iter_start = start_mul | start_div;
  assign shamt      = op_b[SH_W-1:0];
  assign eq         = (op_a == op_b);
  assign lt_s       = ($signed(op_a) < $signed(op_b));
  assign lt_u       = (op_a < op_b);
  assign sra_res    = $signed(op_a) >>> shamt;

  always_comb begin
    base_res = '0;
    case (funct3)
      3'b000: base_res = op_a + op_b;
      3'b001: base_res = op_a << shamt;
      3'b010: base_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011: base_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100: base_res = op_a ^ op_b;
      3'b101: base_res = op_a >> shamt;
      3'b110: base_res = op_a | op_b;
      3'b111: base_res = op_a & op_b;
      default: base_res = '0;
    endcase
  end

  // Single-cycle decode; iterative MUL/DIV only raises start_mul/start_div.
  always_comb begin
    sc_result  = '0;
    sc_br      = 1'b0;
    sc_illegal = 1'b0;
    start_mul  = 1'b0;
    start_div  = 1'b0;
    case (alu_funct)
      CTL_ALU_ADD: sc_result = op_a + op_b;
      CTL_ALU_LUI: sc_result = op_b;
      CTL_ALU_IMM: sc_result = (funct3 == 3'b101 && funct7[5]) ? sra_res : base_res;
      CTL_ALU_REG: begin
        case (funct7)
          7'h00: sc_result = base_res;
          7'h20: begin
            if (funct3 == 3'b000)      sc_result = op_a - op_b;
            else if (funct3 == 3'b101) sc_result = sra_res;
            else                       sc_illegal = 1'b1;
          end
`ifdef ALU_EXEC_MULDIV_EN
          7'h01: begin
            if (!funct3[2])                                 start_mul = 1'b1;
            else if (op_b == ZERO)                          sc_result = funct3[1] ? op_a : ONES;
            else if (!funct3[0] && op_a == SMIN && op_b == ONES) sc_result = funct3[1] ? ZERO : SMIN;
            else                                            start_div = 1'b1;
          end
`endif
          default: sc_illegal = 1'b1;
        endcase
      end
      CTL_ALU_BR: begin
        case (funct3)
          3'b000:  sc_br = eq;
          3'b001:  sc_br = ~eq;
          3'b100:  sc_br = lt_s;
          3'b101:  sc_br = ~lt_s;
          3'b110:  sc_br = lt_u;
          3'b111:  sc_br = ~lt_u;
          default: sc_illegal = 1'b1;
        endcase
        sc_result = {{(XLEN-1){1'b0}}, sc_br};
      end
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] work, work_nxt, prod_fix;
  logic [XLEN-1:0]   opnd, mag_a, mag_b, quo_fix, rem_fix;
  logic [XLEN:0]     tsum;
  logic [2:0]        f3_q;
  logic              a_signed, b_signed, neg_a, neg_b, neg_a_q, neg_b_q;

  assign a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign neg_a    = a_signed & op_a[XLEN-1];
  assign neg_b    = b_signed & op_b[XLEN-1];
  assign mag_a    = neg_a ? -op_a : op_a;
  assign mag_b    = neg_b ? -op_b : op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      work    <= '0;
      opnd    <= '0;
      f3_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && iter_start) begin
        cnt     <= N_CNT;
        f3_q    <= funct3;
        neg_a_q <= neg_a;
        neg_b_q <= neg_b;
        work    <= start_mul ? {ZERO, mag_b} : {ZERO, mag_a};
        opnd    <= start_mul ? mag_a : mag_b;
      end else if (state == S_MUL || state == S_DIV) begin
        cnt  <= cnt - CNT_W'(1);
        work <= work_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && start_mul)      state_nxt = S_MUL;
        else if (accept && start_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // work holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    work_nxt = work;
    tsum     = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (state == S_MUL) begin
        tsum     = {1'b0, work_nxt[2*XLEN-1:XLEN]} + (work_nxt[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        work_nxt = {tsum, work_nxt[XLEN-1:1]};
      end else begin
        tsum = {work_nxt[2*XLEN-1:XLEN], work_nxt[XLEN-1]};
        if (tsum >= {1'b0, opnd}) begin
          tsum     = tsum - {1'b0, opnd};
          work_nxt = {tsum[XLEN-1:0], work_nxt[XLEN-2:0], 1'b1};
        end else begin
          work_nxt = {tsum[XLEN-1:0], work_nxt[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign prod_fix  = (neg_a_q ^ neg_b_q) ? -work : work;
  assign quo_fix   = (neg_a_q ^ neg_b_q) ? -work[XLEN-1:0] : work[XLEN-1:0];
  assign rem_fix   = neg_a_q ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
  assign md_result = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix)
                             : ((f3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
  assign idle      = (state == S_IDLE);
  assign done_fire = (state == S_DONE);
  assign busy      = (state != S_IDLE);
`else
  assign md_result = '0;
  assign idle      = 1'b1;
  assign done_fire = 1'b0;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      br_taken   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (accept && !iter_start) begin
      out_valid  <= 1'b1;
      result     <= sc_result;
      br_taken   <= sc_br;
      illegal_op <= sc_illegal;
    end else if (done_fire) begin
      out_valid  <= 1'b1;
      result     <= md_result;
      br_taken   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized bench for alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
  localparam int XLEN = 32;
  localparam int N    = 32;
  localparam logic [2:0] C_ADD = 3'd0, C_REG = 3'd1, C_IMM = 3'd2, C_BR = 3'd3, C_LUI = 3'd4;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        ill;
    logic        iter;
    logic [31:0] acc_cyc;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, br_taken, illegal_op, busy;
  logic [2:0] alu_funct = '0, funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [31:0] op_a = '0, op_b = '0, result;

  int n_chk = 0, n_err = 0, cyc = 0, n_out = 0, acc_count = 0, start_cyc = 0;
  bit rand_ready = 1'b0, prev_ov = 1'b0, prev_fire = 1'b0;
  logic [31:0] last_res;
  logic last_br, last_ill;
  exp_t q[$];

  alu_exec_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_funct(alu_funct), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .br_taken(br_taken),
    .illegal_op(illegal_op), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] base_op(input logic [2:0] f3, input logic [31:0] a, b, input bit arith);
    int sh = int'(b[4:0]);
    case (f3)
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return arith ? 32'($signed(a) >>> sh) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] af, f3, input logic [6:0] f7, input logic [31:0] a, b);
    exp_t e;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    bit ovf;
    e = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (af)
      C_ADD: e.res = a + b;
      C_LUI: e.res = b;
      C_IMM: e.res = base_op(f3, a, b, f3 == 3'd5 && f7[5]);
      C_REG: begin
        if (f7 == 7'h00) e.res = base_op(f3, a, b, 1'b0);
        else if (f7 == 7'h20 && f3 == 3'd0) e.res = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) e.res = base_op(f3, a, b, 1'b1);
`ifdef ALU_EXEC_MULDIV_EN
        else if (f7 == 7'h01) begin
          case (f3)
            3'd0: begin p = 64'(sa * sb); e.res = p[31:0]; e.iter = 1; end
            3'd1: begin p = 64'(sa * sb); e.res = p[63:32]; e.iter = 1; end
            3'd2: begin p = 64'(sa * longint'(ub)); e.res = p[63:32]; e.iter = 1; end
            3'd3: begin p = ua * ub; e.res = p[63:32]; e.iter = 1; end
            3'd4: if (b == 0) e.res = '1; else begin p = 64'(sa / sb); e.res = p[31:0]; e.iter = !ovf; end
            3'd5: if (b == 0) e.res = '1; else begin p = ua / ub; e.res = p[31:0]; e.iter = 1; end
            3'd6: if (b == 0) e.res = a; else begin p = 64'(sa % sb); e.res = p[31:0]; e.iter = !ovf; end
            default: if (b == 0) e.res = a; else begin p = ua % ub; e.res = p[31:0]; e.iter = 1; end
          endcase
        end
`endif
        else e.ill = 1;
      end
      C_BR: begin
        case (f3)
          3'd0: e.br = (a == b);
          3'd1: e.br = (a != b);
          3'd4: e.br = (sa < sb);
          3'd5: e.br = (sa >= sb);
          3'd6: e.br = (ua < ub);
          3'd7: e.br = (ua >= ub);
          default: e.ill = 1;
        endcase
        e.res = {31'd0, e.br};
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Scoreboard: every valid output cycle is compared with the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev_ov = 0;
        prev_fire = 0;
      end else begin
        if (busy) chk("in_ready_low_when_busy", in_ready, 0);
        if (prev_ov && !prev_fire) chk("out_valid_held", out_valid, 1);
        if (out_valid && (!prev_ov || prev_fire)) start_cyc = cyc;
        if (out_valid) begin
          if (q.size() == 0) fail_now("spurious_out_valid");
          else begin
            e = q[0];
            chk("result", result, e.res);
            chk("br_taken", br_taken, e.br);
            chk("illegal_op", illegal_op, e.ill);
            if (out_ready) begin
              chk("latency", start_cyc - int'(e.acc_cyc), e.iter ? N + 1 : 0);
              last_res = result;
              last_br = br_taken;
              last_ill = illegal_op;
              n_out++;
              void'(q.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          e = model(alu_funct, funct3, funct7, op_a, op_b);
          e.acc_cyc = 32'(cyc + 1);
          q.push_back(e);
          acc_count++;
        end
        prev_ov = out_valid;
        prev_fire = out_valid & out_ready;
      end
    end
  end

  task automatic drive_op(input logic [2:0] af, f3, input logic [6:0] f7, input logic [31:0] a, b);
    alu_funct = af; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
  endtask

  task automatic wait_acc(output int edges);
    int start = acc_count;
    edges = 0;
    while (acc_count == start && edges < 300) begin @(posedge clk); #1; edges++; end
    if (acc_count == start) fail_now("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit chk_busy);
    int start = n_out;
    int k = 0;
    while (n_out == start && k < 200) begin
      @(negedge clk); #1;
      if (n_out == start && chk_busy) chk("in_ready_during_iteration", in_ready, 0);
      k++;
    end
    if (n_out == start) fail_now("output_timeout");
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] af, f3, input logic [6:0] f7, input logic [31:0] a, b, input bit chk_busy);
    int e;
    drive_op(af, f3, f7, a, b);
    wait_acc(e);
    wait_out(chk_busy);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int e;
    logic [31:0] a1, b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_br_taken", br_taken, 0);
    chk("reset_illegal_op", illegal_op, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(C_REG, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 0);
    chk("sra_literal", last_res, 32'hF800_0000);
    chk("sra_not_illegal", last_ill, 0);
    run_op(C_BR, 3'd7, 7'h00, 32'd5, 32'hFFFF_FFFF, 0);
    chk("bgeu_br", last_br, 0);
    chk("bgeu_result", last_res, 0);
    run_op(C_BR, 3'd5, 7'h00, 32'd5, 32'hFFFF_FFFF, 0);
    chk("bge_br", last_br, 1);
    run_op(C_REG, 3'd0, 7'h07, 32'd9, 32'd9, 0);
    chk("bad_funct7_illegal", last_ill, 1);
`ifdef ALU_EXEC_MULDIV_EN
    run_op(C_REG, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    chk("mulh_literal", last_res, 32'h0000_0000);
    run_op(C_REG, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    chk("mul_literal", last_res, 32'h0000_0001);
    run_op(C_REG, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_overflow_literal", last_res, 32'h8000_0000);
    run_op(C_REG, 3'd7, 7'h01, 32'd7, 32'd0, 0);
    chk("remu_by_zero_literal", last_res, 32'd7);
    run_op(C_REG, 3'd5, 7'h01, 32'd7, 32'd0, 0);
    chk("divu_by_zero_literal", last_res, 32'hFFFF_FFFF);
    run_op(C_REG, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 1);
    chk("rem_neg_literal", last_res, 32'hFFFF_FFFF);
`else
    run_op(C_REG, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("mul_disabled_illegal", last_ill, 1);
    chk("mul_disabled_result", last_res, 0);
`endif

    a1 = $urandom; b1 = $urandom;
    out_ready = 1'b0;
    drive_op(C_ADD, 3'd0, 7'h00, a1, b1);
    wait_acc(e);
    drive_op(C_ADD, 3'd0, 7'h00, 32'd100, 32'd23);
    repeat (3) begin
      @(negedge clk); #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", result, a1 + b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_acc(e);
    chk("stall_release_accept_edges", e, 1);
    wait_out(0);
    chk("second_add_after_stall", last_res, 32'd123);

    for (int i = 0; i < 8; i++) begin
      drive_op(C_ADD, 3'd0, 7'h00, $urandom, $urandom);
      wait_acc(e);
      chk("burst_one_per_cycle", e, 1);
    end
    repeat (3) @(posedge clk);
    #1;

`ifdef ALU_EXEC_MULDIV_EN
    drive_op(C_REG, 3'd5, 7'h01, 32'd1234567, 32'd89);
    wait_acc(e);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_mid_div", busy, 1);
`else
    drive_op(C_ADD, 3'd0, 7'h00, 32'd1, 32'd1);
    wait_acc(e);
`endif
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(C_ADD, 3'd0, 7'h00, 32'd2, 32'd3, 0);
    chk("add_after_reset", last_res, 32'd5);

    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 5))
        0, 1: f7 = 7'h00;
        2: f7 = 7'h20;
        3, 4: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      drive_op(3'($urandom_range(0, 7)), 3'($urandom), f7, pick_operand(), pick_operand());
      wait_acc(e);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    begin
      int k = 0;
      while (q.size() != 0 && k < 300) begin @(posedge clk); #1; k++; end
      if (q.size() != 0) fail_now("drain_timeout");
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
